// File: rtl/spi_write_arbiter_pkg.sv
// Shared types and constants for the two-requester SPI write sequencer
// (frame geometry, FSM states, peripheral register map).
package spi_arb_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

  // Write frame: bit 15 set marks a write, then address, then data.
  function automatic logic [FRAME_BITS-1:0] write_frame(input logic [ADDR_W-1:0] addr,
                                                        input logic [DATA_W-1:0] data);
    return {1'b1, addr, data};
  endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Mode-0 SPI frame serialiser: clock divider, 16-bit shift register and bit counter.
// One start pulse sends one frame; idle_next tells the arbiter a new start may be issued.
module spi_frame_tx
  import spi_arb_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NCS_GAP = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  ncs,
  output logic                  sclk,
  output logic                  copi,
  output logic                  busy,
  output logic                  idle_next
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(NCS_GAP - 1);

  state_t                state;
  logic [7:0]            div;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  tail;
  logic                  div_end;

  assign div_end = (div == DIV_LAST);
  // copi is the shift register MSB, so it only moves when the register shifts.
  assign copi    = shreg[FRAME_BITS-1];

  // Lookahead lets the arbiter grant on the edge that returns this block to IDLE.
  assign idle_next = ((state == IDLE) && !start) || ((state == GAP) && (div == GAP_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tail    <= 1'b0;
      ncs     <= 1'b1;
      sclk    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      // NOTE: non-blocking default; any later assignment to div in this block wins.
      div <= div + 8'd1;
      case (state)
        IDLE: begin
          div <= '0;
          if (start) begin
            state   <= SETUP;
            shreg   <= frame;
            bit_cnt <= 4'd15;
            tail    <= 1'b0;
            ncs     <= 1'b0;
            sclk    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SETUP: begin
          if (div_end) begin
            state <= SHIFT;
            sclk  <= 1'b1;
            div   <= '0;
          end
        end
        SHIFT: begin
          if (div_end) begin
            div <= '0;
            if (sclk) begin
              // Falling edge: present the next bit for the low and following high phase.
              sclk <= 1'b0;
              if (bit_cnt == 4'd0) begin
                tail <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt - 4'd1;
                shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
              end
            end else if (tail) begin
              state <= HOLD;
            end else begin
              sclk <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (div_end) begin
            state <= GAP;
            ncs   <= 1'b1;
            shreg <= '0;
            div   <= '0;
          end
        end
        GAP: begin
          if (div == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            div   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_write_arbiter.sv
// Shares one SPI write link between two requesters: arbitration and ready handshake here,
// serialisation in spi_frame_tx. Build option: define SPI_ARB_FIXED_PRIO_EN for fixed priority.
module spi_write_arbiter
  import spi_arb_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NCS_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              ncs,
  output logic              sclk,
  output logic              copi,
  output logic              busy,
  output logic              grant_id
);

  logic                  tx_start;
  logic                  tx_idle_next;
  logic [FRAME_BITS-1:0] tx_frame;
  logic                  grant;
  logic                  pick1;

  assign grant = tx_idle_next && (req0_valid || req1_valid);

`ifdef SPI_ARB_FIXED_PRIO_EN
  always_comb pick1 = !req0_valid;
`else
  logic last_grant;

  always_comb begin
    // NOTE: assign a default before any condition so no path leaves pick1 latched.
    pick1 = !req0_valid;
    if (req0_valid && req1_valid) pick1 = !last_grant;
  end

  // Resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)        last_grant <= 1'b1;
    else if (grant) last_grant <= pick1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      tx_start   <= 1'b0;
      tx_frame   <= '0;
      grant_id   <= 1'b0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      tx_start   <= 1'b0;
      if (grant) begin
        req0_ready <= !pick1;
        req1_ready <= pick1;
        tx_start   <= 1'b1;
        grant_id   <= pick1;
        tx_frame   <= pick1 ? write_frame(req1_addr, req1_data)
                            : write_frame(req0_addr, req0_data);
      end
    end
  end

  spi_frame_tx #(
    .CLK_DIV(CLK_DIV),
    .NCS_GAP(NCS_GAP)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (tx_start),
    .frame    (tx_frame),
    .ncs      (ncs),
    .sclk     (sclk),
    .copi     (copi),
    .busy     (busy),
    .idle_next(tx_idle_next)
  );

endmodule
